tt_sweep_ctrl: RTL and testbench

- Sequencing controller for one 4-input combinational truth-table gate (yosys-mapped NOR/NOT netlist, inputs _0.._3, one output).
- On start, drives the gate through all 16 input vectors and waits a programmable settle time per vector. It then samples the output, assembles the observed 16-bit truth table, and compares it against an expected table.
- Sits between the test/config host and the gate instance in characterisation and regression harnesses.

---
 rtl/tt_sweep_ctrl.sv | 167 ++++++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_ctrl
// Function : steps a 4-input truth-table gate through all 16 vectors, samples
//            its output after a settle delay and compares against a table.
// Revision : 1.0
// ============================================================================
module tt_sweep_ctrl #(
  parameter int         SETTLE_W = 8,
  parameter logic [3:0] IDLE_VEC = 4'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [15:0]         expected_tt,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [3:0]          gate_in,
  input  logic                gate_out,
  output logic                busy,
  output logic                done,
  output logic [15:0]         observed_tt,
  output logic [15:0]         mismatch_mask,
  output logic [4:0]          mismatch_cnt,
  output logic                match
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam logic [3:0] c_LAST_IDX = 4'd15;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_index;
  logic [SETTLE_W-1:0] r_counter;
  logic [SETTLE_W-1:0] r_settle;
  logic [15:0]         r_expected;
  logic [15:0]         r_observed;
  logic [15:0]         r_mask;
  logic [4:0]          r_cnt;
  logic                r_match;
  logic [3:0]          r_gate_in;
  logic                r_busy;
  logic                r_done;
  logic [15:0]         w_mask;
  logic [4:0]          w_cnt;

  assign w_mask = r_observed ^ r_expected;

  always_comb begin
    w_cnt = 5'd0;
    for (int i = 0; i < 16; i++) begin
      w_cnt = w_cnt + {4'd0, w_mask[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort)                           w_state_nxt = ST_IDLE;
        else if (r_counter == '0)            w_state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (abort)                           w_state_nxt = ST_IDLE;
        else if (r_index == c_LAST_IDX)      w_state_nxt = ST_FINISH;
        else                                 w_state_nxt = ST_SETTLE;
      end
      ST_FINISH: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index    <= 4'd0;
      r_counter  <= '0;
      r_settle   <= '0;
      r_expected <= 16'd0;
      r_observed <= 16'd0;
      r_mask     <= 16'd0;
      r_cnt      <= 5'd0;
      r_match    <= 1'b0;
      r_gate_in  <= IDLE_VEC;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_expected <= expected_tt;
            r_settle   <= settle_cycles;
            r_observed <= 16'd0;
            r_mask     <= 16'd0;
            r_cnt      <= 5'd0;
            r_match    <= 1'b0;
            r_index    <= 4'd0;
            r_gate_in  <= 4'd0;
            r_counter  <= settle_cycles;
            r_busy     <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            r_gate_in <= IDLE_VEC;
            r_busy    <= 1'b0;
          end else if (r_counter != '0) begin
            r_counter <= r_counter - {{(SETTLE_W-1){1'b0}}, 1'b1};
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            r_gate_in <= IDLE_VEC;
            r_busy    <= 1'b0;
          end else begin
            // Index 0 lands in the MSB so the table reads like the gate's hex function.
            r_observed[c_LAST_IDX - r_index] <= gate_out;
            if (r_index != c_LAST_IDX) begin
              r_index   <= r_index + 4'd1;
              r_gate_in <= r_index + 4'd1;
              r_counter <= r_settle;
            end
          end
        end
        ST_FINISH: begin
          r_mask    <= w_mask;
          r_cnt     <= w_cnt;
          r_match   <= (w_cnt == 5'd0);
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_gate_in <= IDLE_VEC;
        end
        default: begin
          r_busy    <= 1'b0;
          r_gate_in <= IDLE_VEC;
        end
      endcase
    end
  end

  assign gate_in       = r_gate_in;
  assign busy          = r_busy;
  assign done          = r_done;
  assign observed_tt   = r_observed;
  assign mismatch_mask = r_mask;
  assign mismatch_cnt  = r_cnt;
  assign match         = r_match;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_ctrl.sv
`default_nettype none
// Testbench for tt_sweep_ctrl: gate model (combinational or 3-cycle delayed)
// and a timing/table reference model derived from the sweep rules.
module tb_tt_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] expected_tt = 16'd0;
  logic [7:0]  settle_cycles = 8'd0;
  logic [3:0]  gate_in;
  logic        gate_out;
  logic        busy;
  logic        done;
  logic [15:0] observed_tt;
  logic [15:0] mismatch_mask;
  logic [4:0]  mismatch_cnt;
  logic        match;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] gate_fn = 16'h30CE;
  bit          use_delay = 1'b0;
  logic [3:0]  d1 = 4'd0, d2 = 4'd0, d3 = 4'd0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= gate_in;
    d2 <= d1;
    d3 <= d2;
  end

  assign gate_out = use_delay ? gate_fn[4'd15 - d3] : gate_fn[4'd15 - gate_in];

  tt_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .expected_tt(expected_tt), .settle_cycles(settle_cycles),
    .gate_in(gate_in), .gate_out(gate_out), .busy(busy), .done(done),
    .observed_tt(observed_tt), .mismatch_mask(mismatch_mask),
    .mismatch_cnt(mismatch_cnt), .match(match)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vector on gate_in after the k-th edge counted from the accept edge (k=0).
  function automatic logic [3:0] gi_at(input int k, input int s);
    if (k < 0) return 4'h0;
    if (k / (s + 2) > 15) return 4'd15;
    return 4'(k / (s + 2));
  endfunction

  // Table the controller should assemble: vector i is sampled on edge
  // (i+1)*(s+2); the gate then shows the vector applied dly edges earlier.
  function automatic logic [15:0] model_obs(input logic [15:0] fn, input int s, input int dly);
    logic [15:0] r;
    logic [3:0]  v;
    r = 16'd0;
    for (int i = 0; i < 16; i++) begin
      v = gi_at((i + 1) * (s + 2) - 1 - dly, s);
      r[15 - i] = fn[4'd15 - v];
    end
    return r;
  endfunction

  function automatic int popcnt16(input logic [15:0] x);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(x[i]);
    return c;
  endfunction

  // Full sweep; optionally re-pulse start with new inputs at edge repulse_k.
  task automatic sweep(input string tag, input logic [15:0] exp, input int s,
                       input bit with_abort, input int repulse_k,
                       output logic [15:0] obs_got);
    int          total, bad;
    logic [15:0] mobs;
    total = 16 * (s + 2);
    mobs  = model_obs(gate_fn, s, use_delay ? 3 : 0);
    expected_tt   = exp;
    settle_cycles = 8'(s);
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    bad = 0;
    for (int k = 0; k <= total; k++) begin
      if (gate_in !== gi_at(k, s) || busy !== 1'b1 || done !== 1'b0) bad++;
      if (k == repulse_k) begin
        start = 1'b1;
        expected_tt = ~exp;
        settle_cycles = 8'(s + 5);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check({tag, "_seq"}, bad, 0);
    check({tag, "_done"}, {busy, done, gate_in}, {1'b0, 1'b1, 4'h0});
    check({tag, "_obs"}, observed_tt, mobs);
    check({tag, "_mask"}, mismatch_mask, mobs ^ exp);
    check({tag, "_cnt"}, mismatch_cnt, popcnt16(mobs ^ exp));
    check({tag, "_match"}, match, (mobs == exp));
    obs_got = observed_tt;
    tick();
    check({tag, "_done_low"}, done, 1'b0);
    for (int k = 0; k < 4; k++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] obs;
    logic [15:0] efn;
    int          bad;

    #12;
    check("reset_state", {busy, done, gate_in, observed_tt, mismatch_mask, mismatch_cnt, match},
          {1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 5'd0, 1'b0});
    rst_n = 1'b1;
    tick();

    // Reference function with combinational gate.
    gate_fn = 16'h30CE;
    sweep("t1", 16'h30CE, 0, 1'b0, -1, obs);
    check("t1_fn", obs, 16'h30CE);
    sweep("t2a", 16'h30CF, 0, 1'b0, -1, obs);
    check("t2a_cnt1", mismatch_cnt, 5'd1);
    sweep("t2b", 16'hCF31, 0, 1'b0, -1, obs);
    check("t2b_cnt16", mismatch_cnt, 5'd16);

    // Delayed gate: long enough settle gives the right table, zero settle does not.
    use_delay = 1'b1;
    sweep("t3a", 16'h30CE, 3, 1'b0, -1, obs);
    check("t3a_fn", obs, 16'h30CE);
    sweep("t3b", 16'h30CE, 0, 1'b0, -1, obs);
    check("t3b_wrong", (obs != 16'h30CE), 1'b1);
    use_delay = 1'b0;

    // Abort while vector 5 settles (S=1).
    gate_fn = 16'($urandom);
    expected_tt = 16'($urandom);
    settle_cycles = 8'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 16; k++) tick();
    check("t4_at_idx5", gate_in, 4'd5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort", {busy, done, gate_in}, {1'b0, 1'b0, 4'h0});
    check("t4_partial", observed_tt, {gate_fn[15:11], 11'd0});
    check("t4_result0", {mismatch_mask, mismatch_cnt, match}, 22'd0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (done !== 1'b0 || busy !== 1'b0) bad++;
      tick();
    end
    check("t4_no_done", bad, 0);
    sweep("t4_after", 16'($urandom), 1, 1'b0, -1, obs);

    // Start re-pulsed mid-sweep with changed inputs; start+abort together at accept.
    sweep("t5", 16'h1234, 2, 1'b1, 7 * 4 + 1, obs);

    // Asynchronous reset between edges.
    expected_tt = 16'hFFFF;
    settle_cycles = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async", {busy, done, gate_in, observed_tt, mismatch_mask, mismatch_cnt, match},
          {1'b0, 1'b0, 4'h0, 16'h0, 16'h0, 5'd0, 1'b0});
    tick();
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      if (done !== 1'b0 || busy !== 1'b0 || gate_in !== 4'h0) bad++;
      tick();
    end
    check("t6_quiet", bad, 0);

    // Randomized sweeps against the reference model.
    for (int n = 0; n < 8; n++) begin
      gate_fn = 16'($urandom);
      efn = ($urandom_range(0, 2) == 0) ? gate_fn : 16'($urandom);
      use_delay = ($urandom_range(0, 3) == 0);
      sweep($sformatf("rnd%0d", n), efn, $urandom_range(0, 4), 1'b0, -1, obs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
